display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl.sv | 150 +++++++++++++++
 tb/tb_display_scan_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with per-slot blanking,
// leading-zero suppression and frame-synchronous data update.
module display_scan_ctrl #(
   parameter int TICK_DIV     = 100000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] digits,
   input  logic [3:0]  dp_mask,
   input  logic [3:0]  digit_en,
   input  logic        lz_suppress,
   input  logic        load,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_done
);

   localparam int            CW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX   = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);

   typedef enum logic [0:0] {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_t;

   state_t        state_r, state_nxt_s;
   logic [CW-1:0] cnt_r, cnt_nxt_s;
   logic [1:0]    idx_r, idx_nxt_s;
   logic          slot_wrap_s, frame_wrap_s;
   logic [15:0]   pend_dig_r, act_dig_r;
   logic [3:0]    pend_dp_r, act_dp_r;
   logic [3:0]    nib_s;
   logic          dp_bit_s;
   logic [3:0]    lz_s;
   logic [3:0]    an_nxt_s, an_r;
   logic [6:0]    seg_nxt_s, seg_r;
   logic          dp_nxt_s, dp_r, frame_done_r;

   function automatic logic [6:0] hex7(input logic [3:0] nib);
      case (nib)
         4'h0:    hex7 = 7'b1000000;
         4'h1:    hex7 = 7'b1111001;
         4'h2:    hex7 = 7'b0100100;
         4'h3:    hex7 = 7'b0110000;
         4'h4:    hex7 = 7'b0011001;
         4'h5:    hex7 = 7'b0010010;
         4'h6:    hex7 = 7'b0000010;
         4'h7:    hex7 = 7'b1111000;
         4'h8:    hex7 = 7'b0000000;
         4'h9:    hex7 = 7'b0010000;
         4'hA:    hex7 = 7'b0001000;
         4'hB:    hex7 = 7'b0000011;
         4'hC:    hex7 = 7'b1000110;
         4'hD:    hex7 = 7'b0100001;
         4'hE:    hex7 = 7'b0000110;
         4'hF:    hex7 = 7'b0001110;
         default: hex7 = 7'b1111111;
      endcase
   endfunction

   // Slot/digit counters and blank/drive state transitions
   always_comb begin
      slot_wrap_s  = (cnt_r == CNT_MAX);
      frame_wrap_s = slot_wrap_s && (idx_r == 2'd3);
      cnt_nxt_s    = slot_wrap_s ? {CW{1'b0}} : cnt_r + CW'(1);
      idx_nxt_s    = slot_wrap_s ? idx_r + 2'd1 : idx_r;
      state_nxt_s  = ST_BLANK;
      case (state_r)
         ST_BLANK: begin
            if (cnt_nxt_s >= BLANK_LIM) state_nxt_s = ST_DRIVE;
            else                        state_nxt_s = ST_BLANK;
         end
         ST_DRIVE: begin
            if (slot_wrap_s) state_nxt_s = ST_BLANK;
            else             state_nxt_s = ST_DRIVE;
         end
         default: state_nxt_s = ST_BLANK;
      endcase
   end

   // Active digit selection, leading-zero detection and output decode
   always_comb begin
      case (idx_r)
         2'd0:    nib_s = act_dig_r[3:0];
         2'd1:    nib_s = act_dig_r[7:4];
         2'd2:    nib_s = act_dig_r[11:8];
         2'd3:    nib_s = act_dig_r[15:12];
         default: nib_s = 4'h0;
      endcase
      dp_bit_s = act_dp_r[idx_r];
      // digit k blanks only if it and every higher digit is zero with no dp
      lz_s[3] = (act_dig_r[15:12] == 4'h0) && !act_dp_r[3];
      lz_s[2] = lz_s[3] && (act_dig_r[11:8] == 4'h0) && !act_dp_r[2];
      lz_s[1] = lz_s[2] && (act_dig_r[7:4] == 4'h0) && !act_dp_r[1];
      lz_s[0] = 1'b0;
      an_nxt_s  = 4'b1111;
      seg_nxt_s = 7'h7F;
      dp_nxt_s  = 1'b1;
      if (state_r == ST_DRIVE) begin
         if (digit_en[idx_r] && !(lz_suppress && lz_s[idx_r])) an_nxt_s = ~(4'b0001 << idx_r);
         else                                                  an_nxt_s = 4'b1111;
         seg_nxt_s = hex7(nib_s);
         dp_nxt_s  = ~dp_bit_s;
      end else begin
         an_nxt_s  = 4'b1111;
         seg_nxt_s = 7'h7F;
         dp_nxt_s  = 1'b1;
      end
   end

   // State, data registers and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r      <= ST_BLANK;
         cnt_r        <= {CW{1'b0}};
         idx_r        <= 2'd0;
         pend_dig_r   <= 16'h0000;
         pend_dp_r    <= 4'h0;
         act_dig_r    <= 16'h0000;
         act_dp_r     <= 4'h0;
         an_r         <= 4'b1111;
         seg_r        <= 7'h7F;
         dp_r         <= 1'b1;
         frame_done_r <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         cnt_r        <= cnt_nxt_s;
         idx_r        <= idx_nxt_s;
         an_r         <= an_nxt_s;
         seg_r        <= seg_nxt_s;
         dp_r         <= dp_nxt_s;
         frame_done_r <= frame_wrap_s;
         if (load) begin
            pend_dig_r <= digits;
            pend_dp_r  <= dp_mask;
         end
         // a load on the boundary bypasses pending so this frame gets it
         if (frame_wrap_s) begin
            act_dig_r <= load ? digits  : pend_dig_r;
            act_dp_r  <= load ? dp_mask : pend_dp_r;
         end
      end
   end

   assign an         = an_r;
   assign seg        = seg_r;
   assign dp         = dp_r;
   assign frame_done = frame_done_r;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with TICK_DIV=8, BLANK_CYCLES=2
// (32-cycle frames); expected values are hand-derived per slot.
module tb_display_scan_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] digits = 16'h0000;
   logic [3:0]  dp_mask = 4'h0;
   logic [3:0]  digit_en = 4'hF;
   logic        lz_suppress = 1'b0;
   logic        load = 1'b0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [15:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

   display_scan_ctrl #(.TICK_DIV(8), .BLANK_CYCLES(2)) dut (
      .clock(clock), .reset(reset), .digits(digits), .dp_mask(dp_mask),
      .digit_en(digit_en), .lz_suppress(lz_suppress), .load(load),
      .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
   );

   always #5 clock = ~clock;

   // One slot = 8 samples: 2 blank then 6 driven; optional load after sample load_at
   task automatic check_slot(input string name, input int slot, input logic [3:0] an_e,
                             input logic [6:0] seg_e, input logic dp_e, input int load_at,
                             input logic [15:0] ld_d, input logic [3:0] ld_dp);
      logic [3:0] ea;
      logic [6:0] es;
      logic       ed, ef;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         if (i < 2) begin ea = 4'b1111; es = 7'h7F; ed = 1'b1; end
         else       begin ea = an_e;    es = seg_e; ed = dp_e; end
         ef = (slot == 3) && (i == 7);
         n_checks++;
         if (an !== ea) begin n_fail++; $display("FAIL %s slot%0d cyc%0d an: got %b expected %b", name, slot, i, an, ea); end
         n_checks++;
         if (seg !== es) begin n_fail++; $display("FAIL %s slot%0d cyc%0d seg: got %b expected %b", name, slot, i, seg, es); end
         n_checks++;
         if (dp !== ed) begin n_fail++; $display("FAIL %s slot%0d cyc%0d dp: got %b expected %b", name, slot, i, dp, ed); end
         n_checks++;
         if (frame_done !== ef) begin n_fail++; $display("FAIL %s slot%0d cyc%0d frame_done: got %b expected %b", name, slot, i, frame_done, ef); end
         if (i == load_at) begin digits = ld_d; dp_mask = ld_dp; load = 1'b1; end
         else load = 1'b0;
      end
   endtask

   task automatic run_frame(input string name, input logic [15:0] an_e, input logic [27:0] seg_e,
                            input logic [3:0] dp_e, input int load_slot, input int load_at,
                            input logic [15:0] ld_d, input logic [3:0] ld_dp);
      for (int k = 0; k < 4; k++)
         check_slot(name, k, an_e[4*k +: 4], seg_e[7*k +: 7], dp_e[k],
                    (k == load_slot) ? load_at : -1, ld_d, ld_dp);
   endtask

   // Reset held for one edge, outputs checked, released at a falling edge
   task automatic do_reset(input string name);
      @(negedge clock);
      reset = 1'b1; load = 1'b0; digit_en = 4'hF; lz_suppress = 1'b0; dp_mask = 4'h0;
      @(negedge clock);
      n_checks++;
      if (an !== 4'b1111) begin n_fail++; $display("FAIL %s an: got %b expected 1111", name, an); end
      n_checks++;
      if (seg !== 7'h7F) begin n_fail++; $display("FAIL %s seg: got %b expected 1111111", name, seg); end
      n_checks++;
      if (dp !== 1'b1) begin n_fail++; $display("FAIL %s dp: got %b expected 1", name, dp); end
      n_checks++;
      if (frame_done !== 1'b0) begin n_fail++; $display("FAIL %s frame_done: got %b expected 0", name, frame_done); end
      reset = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      do_reset("reset");
   endtask

   task automatic test_scan();
      do_reset("scan_rst");
      run_frame("scan_f0", AN_ALL, {4{7'h40}}, 4'hF, 0, 0, 16'h1234, 4'h0);
      run_frame("scan_f1", AN_ALL, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, -1, -1, 16'h0000, 4'h0);
      run_frame("scan_f2", AN_ALL, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, -1, -1, 16'h0000, 4'h0);
   endtask

   task automatic test_lz();
      do_reset("lz_rst");
      lz_suppress = 1'b1;
      run_frame("lz_f0", {4'b1111, 4'b1111, 4'b1111, 4'b1110}, {4{7'h40}}, 4'hF, 0, 0, 16'h0005, 4'h0);
      run_frame("lz_f1", {4'b1111, 4'b1111, 4'b1111, 4'b1110}, {7'h40, 7'h40, 7'h40, 7'h12}, 4'hF, -1, -1, 16'h0000, 4'h0);
      lz_suppress = 1'b0;
      run_frame("lz_off", AN_ALL, {7'h40, 7'h40, 7'h40, 7'h12}, 4'hF, -1, -1, 16'h0000, 4'h0);
   endtask

   task automatic test_load_timing();
      do_reset("ld_rst");
      run_frame("ld_f0", AN_ALL, {4{7'h40}}, 4'hF, 0, 0, 16'h1234, 4'h0);
      run_frame("ld_mid", AN_ALL, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 1, 2, 16'hAAAA, 4'h0);
      run_frame("ld_new", AN_ALL, {4{7'h08}}, 4'hF, 3, 6, 16'hF0E8, 4'b0001);
      run_frame("ld_bnd", AN_ALL, {7'h0E, 7'h40, 7'h06, 7'h00}, 4'b1110, -1, -1, 16'h0000, 4'h0);
   endtask

   task automatic test_digit_en();
      do_reset("en_rst");
      digit_en = 4'b0101;
      run_frame("en_f0", {4'b1111, 4'b1011, 4'b1111, 4'b1110}, {4{7'h40}}, 4'hF, 0, 0, 16'h8888, 4'h0);
      run_frame("en_f1", {4'b1111, 4'b1011, 4'b1111, 4'b1110}, {4{7'h00}}, 4'hF, -1, -1, 16'h0000, 4'h0);
   endtask

   task automatic test_reset_mid();
      do_reset("rm_rst");
      run_frame("rm_f0", AN_ALL, {4{7'h40}}, 4'hF, 0, 0, 16'h1234, 4'h0);
      check_slot("rm_s0", 0, 4'b1110, 7'h19, 1'b1, -1, 16'h0000, 4'h0);
      check_slot("rm_s1", 1, 4'b1101, 7'h30, 1'b1, -1, 16'h0000, 4'h0);
      repeat (4) @(negedge clock);
      n_checks++;
      if (an !== 4'b1011 || seg !== 7'h24) begin
         n_fail++; $display("FAIL rm_drive2 an/seg: got %b/%b expected 1011/0100100", an, seg);
      end
      reset = 1'b1;
      @(negedge clock);
      n_checks++;
      if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
         n_fail++; $display("FAIL rm_reset an/seg/dp/fd: got %b/%b/%b/%b expected 1111/1111111/1/0", an, seg, dp, frame_done);
      end
      reset = 1'b0;
      check_slot("rm_after", 0, 4'b1110, 7'h40, 1'b1, -1, 16'h0000, 4'h0);
      check_slot("rm_after", 1, 4'b1101, 7'h40, 1'b1, -1, 16'h0000, 4'h0);
   endtask

   initial begin
      test_reset();
      test_scan();
      test_lz();
      test_load_timing();
      test_digit_en();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
